// File: rtl/coso_pkg.sv
// coso_pkg: shared channel state, default constants and window compare for the COSO calibration unit
package coso_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, ADJUST, LOCKED, FAIL} ch_state_e;
  localparam int NCH_DEF = 2;
  localparam int CW_DEF = 8;
  localparam int SEL_W_DEF = 8;
  localparam int OUT_W_DEF = 16;
  localparam int AVG_LOG_DEF = 2;
  localparam int SETTLE_N_DEF = 2;
  localparam int RELOCK_N_DEF = 4;
  localparam int REP_CUTOFF_DEF = 32;
  localparam int WIN_W = 16;
  function automatic logic in_window(input logic [WIN_W-1:0] count, lo, hi);
    return count >= lo && count <= hi;
  endfunction
endpackage

// File: rtl/coso_cal_ch.sv
// coso_cal_ch: one channel's calibration FSM, averaging accumulator, cro B select and relock counter
module coso_cal_ch
  import coso_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter logic [SEL_W-1:0] SEL_INIT = 8'h80,
  parameter int AVG_LOG = AVG_LOG_DEF,
  parameter int SETTLE_N = SETTLE_N_DEF,
  parameter int RELOCK_N = RELOCK_N_DEF
) (
  input  logic             clk,
  input  logic             rst_x,
  input  logic             en,
  input  logic [CW-1:0]    lo,
  input  logic [CW-1:0]    hi,
  input  logic [CW-1:0]    cnt,
  input  logic             stb,
  output ch_state_e        state,
  output logic [SEL_W-1:0] sel_b,
  output logic             dstb,
  output logic             dlsb
);
  localparam int AW = CW + AVG_LOG;
  ch_state_e state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [7:0] n_q, n_d;
  logic win;
  logic [CW-1:0] avg;
  // next-state: settle, average, step the select, then watch for drift while locked
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    acc_d = acc_q;
    n_d = n_q;
    win = in_window(WIN_W'(cnt), WIN_W'(lo), WIN_W'(hi));
    avg = CW'(acc_q >> AVG_LOG);
    if (!en) begin
      state_d = IDLE;
      n_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SETTLE;
          n_d = '0;
        end
        SETTLE: if (stb) begin
          n_d = n_q + 8'd1;
          if (n_q == 8'(SETTLE_N - 1)) begin
            state_d = MEASURE;
            n_d = '0;
            acc_d = '0;
          end
        end
        MEASURE: if (stb) begin
          acc_d = acc_q + AW'(cnt);
          n_d = n_q + 8'd1;
          if (n_q == 8'((1 << AVG_LOG) - 1)) begin
            state_d = ADJUST;
            n_d = '0;
          end
        end
        ADJUST: begin
          n_d = '0;
          if (avg < lo) begin
            state_d = &sel_q ? FAIL : SETTLE;
            sel_d = &sel_q ? sel_q : sel_q + 1'b1;
          end else if (avg > hi) begin
            state_d = sel_q == '0 ? FAIL : SETTLE;
            sel_d = sel_q == '0 ? sel_q : sel_q - 1'b1;
          end else begin
            state_d = LOCKED;
          end
        end
        LOCKED: if (stb) begin
          n_d = win ? '0 : n_q + 8'd1;
          if (!win && n_q == 8'(RELOCK_N - 1)) begin
            state_d = SETTLE;
            n_d = '0;
          end
        end
        FAIL: state_d = FAIL;
        default: state_d = IDLE;
      endcase
    end
  end
  // channel state registers; select survives enable drops, only reset reloads it
  always_ff @(posedge clk) begin
    if (!rst_x) begin
      state_q <= IDLE;
      sel_q <= SEL_INIT;
      acc_q <= '0;
      n_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      acc_q <= acc_d;
      n_q <= n_d;
    end
  end
  assign state = state_q;
  assign sel_b = sel_q;
  assign dstb = en && stb && state_q == LOCKED && win;
  assign dlsb = cnt[0];
endmodule

// File: rtl/coso_cal_unit.sv
// coso_cal_unit: multi-channel COSO TRNG with auto-calibration, XOR combiner and word packer; define COSO_HEALTH_EN for the repetition-count health test
module coso_cal_unit
  import coso_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW = CW_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter logic [SEL_W-1:0] SEL_INIT = 8'h80,
  parameter int OUT_W = OUT_W_DEF,
  parameter int AVG_LOG = AVG_LOG_DEF,
  parameter int SETTLE_N = SETTLE_N_DEF,
  parameter int RELOCK_N = RELOCK_N_DEF,
  parameter int REP_CUTOFF = REP_CUTOFF_DEF
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  input  logic                 RNG_EN,
  input  logic [CW-1:0]        CNT_LO,
  input  logic [CW-1:0]        CNT_HI,
  input  logic [NCH*CW-1:0]    CNT_IN,
  input  logic [NCH-1:0]       CNT_EN,
  output logic [NCH*SEL_W-1:0] CRO_SEL_A,
  output logic [NCH*SEL_W-1:0] CRO_SEL_B,
  output logic                 CRO_EN,
  output logic [OUT_W-1:0]     DATA_OUT,
  output logic                 DATA_EN,
  output logic                 CAL_DONE,
  output logic                 CAL_FAIL,
  output logic                 HEALTH_ERR
);
  localparam int BW = $clog2(OUT_W);
  ch_state_e st [NCH];
  logic [NCH-1:0] dstb, dlsb, locked, failed, accept;
  logic [NCH-1:0] pend_q, pend_d, lsb_q, lsb_d;
  logic [OUT_W-1:0] word_q, word_d, word_new, data_q, data_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic cro_en_q, cal_done_q, cal_done_d, cal_fail_q, cal_fail_d, data_en_q, data_en_d, herr_q, herr_d;
  logic fire, bit_x, last;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    coso_cal_ch #(
      .CW(CW), .SEL_W(SEL_W), .SEL_INIT(SEL_INIT), .AVG_LOG(AVG_LOG),
      .SETTLE_N(SETTLE_N), .RELOCK_N(RELOCK_N)
    ) u_ch (
      .clk(CLK), .rst_x(RST_X), .en(RNG_EN), .lo(CNT_LO), .hi(CNT_HI),
      .cnt(CNT_IN[i*CW +: CW]), .stb(CNT_EN[i]), .state(st[i]),
      .sel_b(CRO_SEL_B[i*SEL_W +: SEL_W]), .dstb(dstb[i]), .dlsb(dlsb[i])
    );
    assign locked[i] = st[i] == LOCKED;
    assign failed[i] = st[i] == FAIL;
  end
`ifdef COSO_HEALTH_EN
  localparam int RW = $clog2(REP_CUTOFF + 1) + 1;
  logic [RW-1:0] rep_q, rep_d;
  logic last_q, last_d;
  // repetition count over the combined stream; any run of REP_CUTOFF equal bits latches the error
  always_comb begin
    rep_d = fire ? ((rep_q != '0 && bit_x == last_q) ? rep_q + 1'b1 : RW'(1)) : rep_q;
    last_d = fire ? bit_x : last_q;
    herr_d = herr_q | (rep_d >= RW'(REP_CUTOFF));
  end
  // health test state
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      rep_q <= '0;
      last_q <= 1'b0;
    end else begin
      rep_q <= rep_d;
      last_q <= last_d;
    end
  end
`else
  assign herr_d = 1'b0;
`endif
  // combine one LSB per channel, pack LSB-first, and publish full words
  always_comb begin
    fire = cal_done_q && &pend_q;
    bit_x = ^lsb_q;
    last = bitcnt_q == BW'(OUT_W - 1);
    word_new = word_q | (OUT_W'(bit_x) << bitcnt_q);
    accept = dstb & (~pend_q | {NCH{fire}});
    pend_d = cal_done_q ? (accept | (pend_q & ~{NCH{fire}})) : '0;
    lsb_d = (lsb_q & ~accept) | (dlsb & accept);
    word_d = !cal_done_q ? '0 : fire ? (last ? '0 : word_new) : word_q;
    bitcnt_d = !cal_done_q ? '0 : fire ? (last ? '0 : bitcnt_q + 1'b1) : bitcnt_q;
    data_en_d = fire && last && !herr_d;
    data_d = data_en_d ? word_new : data_q;
    cal_done_d = RNG_EN && &locked;
    cal_fail_d = cal_fail_q | |failed;
  end
  // output and packer registers
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      pend_q <= '0;
      lsb_q <= '0;
      word_q <= '0;
      bitcnt_q <= '0;
      data_q <= '0;
      data_en_q <= 1'b0;
      cro_en_q <= 1'b0;
      cal_done_q <= 1'b0;
      cal_fail_q <= 1'b0;
      herr_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      lsb_q <= lsb_d;
      word_q <= word_d;
      bitcnt_q <= bitcnt_d;
      data_q <= data_d;
      data_en_q <= data_en_d;
      cro_en_q <= RNG_EN;
      cal_done_q <= cal_done_d;
      cal_fail_q <= cal_fail_d;
      herr_q <= herr_d;
    end
  end
  assign CRO_SEL_A = {NCH{SEL_INIT}};
  assign CRO_EN = cro_en_q;
  assign DATA_OUT = data_q;
  assign DATA_EN = data_en_q;
  assign CAL_DONE = cal_done_q;
  assign CAL_FAIL = cal_fail_q;
  assign HEALTH_ERR = herr_q;
endmodule

// File: tb/tb_coso_cal_unit.sv
// tb_coso_cal_unit: scoreboard bench for coso_cal_unit (calibration, combining, packing, fail and health paths)
module tb_coso_cal_unit;
  logic clk = 1'b0;
  logic rst_x = 1'b0;
  logic rng_en = 1'b0;
  logic [7:0] cnt_lo = 8'd20;
  logic [7:0] cnt_hi = 8'd60;
  logic [15:0] cnt_in = '0;
  logic [1:0] cnt_en = '0;
  logic [15:0] sel_a, sel_b, data_out;
  logic cro_en, data_en, cal_done, cal_fail, health_err;
  logic [15:0] exp_q [$];
  int n_chk = 0;
  int n_bad = 0;
  int en_cnt = 0;
  int exp_words = 0;
  int mcnt = 0;
  int mrep = 0;
  logic [15:0] mword = '0;
  logic mlast = 1'b0;
  logic mherr = 1'b0;

  always #5 clk = ~clk;

  coso_cal_unit dut (
    .CLK(clk), .RST_X(rst_x), .RNG_EN(rng_en), .CNT_LO(cnt_lo), .CNT_HI(cnt_hi),
    .CNT_IN(cnt_in), .CNT_EN(cnt_en), .CRO_SEL_A(sel_a), .CRO_SEL_B(sel_b),
    .CRO_EN(cro_en), .DATA_OUT(data_out), .DATA_EN(data_en), .CAL_DONE(cal_done),
    .CAL_FAIL(cal_fail), .HEALTH_ERR(health_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] c0, input logic [7:0] c1, input logic [1:0] m);
    @(negedge clk);
    cnt_in = {c1, c0};
    cnt_en = m;
    @(negedge clk);
    cnt_en = '0;
  endtask

  task automatic pair(input logic [7:0] c0, input logic [7:0] c1);
    logic b;
    b = c0[0] ^ c1[0];
`ifdef COSO_HEALTH_EN
    mrep = (mrep != 0 && b == mlast) ? mrep + 1 : 1;
    mlast = b;
    if (mrep >= 32) mherr = 1'b1;
`endif
    mword[mcnt] = b;
    mcnt++;
    if (mcnt == 16) begin
      if (!mherr) begin
        exp_q.push_back(mword);
        exp_words++;
      end
      mcnt = 0;
      mword = '0;
    end
    strobe(c0, c1, 2'b11);
    idle(2);
  endtask

  always @(negedge clk) begin
    if (rst_x && data_en) begin
      en_cnt++;
      if (exp_q.size() == 0) check("data_extra", 32'(data_out), 32'hFFFF_FFFF);
      else check("data_word", 32'(data_out), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, wbase;
    rst_x = 1'b0;
    rng_en = 1'b1;
    strobe(8'd10, 8'd40, 2'b11);
    idle(2);
    check("rst_data", 32'(data_out), 0);
    check("rst_den", 32'(data_en), 0);
    check("rst_croen", 32'(cro_en), 0);
    check("rst_done", 32'(cal_done), 0);
    check("rst_fail", 32'(cal_fail), 0);
    check("rst_herr", 32'(health_err), 0);
    check("rst_sel_a", 32'(sel_a), 32'h8080);
    check("rst_sel_b", 32'(sel_b), 32'h8080);
    rst_x = 1'b1;
    repeat (18) begin strobe(8'd10, 8'd40, 2'b11); idle(1); end
    check("cal_sel0", 32'(sel_b[7:0]), 32'h83);
    check("cal_sel1", 32'(sel_b[15:8]), 32'h80);
    check("cal_notdone", 32'(cal_done), 0);
    check("croen_on", 32'(cro_en), 1);
    repeat (5) begin strobe(8'd40, 8'd40, 2'b11); idle(1); end
    strobe(8'd40, 8'd40, 2'b11);
    idle(1);
    check("done_early", 32'(cal_done), 0);
    idle(1);
    check("done_lat", 32'(cal_done), 1);
    base = en_cnt;
    wbase = exp_words;
    for (int i = 0; i < 16; i++) pair((i % 2 == 0) ? 8'd41 : 8'd40, 8'd41);
    idle(1);
    check("aaaa_words", en_cnt - base, 32'(exp_words - wbase));
    check("aaaa_val", 32'(data_out), 32'hAAAA);
    check("aaaa_pulse", 32'(data_en), 0);
    base = en_cnt;
    wbase = exp_words;
    for (int i = 0; i < 10; i++) pair(8'(20 + $urandom_range(40)), 8'(20 + $urandom_range(40)));
    repeat (4) begin strobe(8'd0, 8'd100, 2'b10); idle(1); end
    idle(2);
    check("drift_drop", 32'(cal_done), 0);
    mcnt = 0;
    mword = '0;
    repeat (6) begin strobe(8'd0, 8'd60, 2'b10); idle(1); end
    idle(2);
    check("relock_hi", 32'(cal_done), 1);
    check("relock_sel1", 32'(sel_b[15:8]), 32'h80);
    for (int i = 0; i < 16; i++) pair(8'(20 + $urandom_range(40)), 8'(20 + $urandom_range(40)));
    idle(1);
    check("relock_words", en_cnt - base, 32'(exp_words - wbase));
    check("relock_one", en_cnt - base, 1);
    base = en_cnt;
    repeat (4) begin strobe(8'd5, 8'd40, 2'b11); idle(1); end
    repeat (124 * 6) begin strobe(8'd5, 8'd40, 2'b11); idle(1); end
    idle(2);
    check("sel_max", 32'(sel_b[7:0]), 32'hFF);
    check("fail_early", 32'(cal_fail), 0);
    repeat (6) begin strobe(8'd5, 8'd40, 2'b11); idle(1); end
    idle(3);
    check("fail_set", 32'(cal_fail), 1);
    check("fail_sel", 32'(sel_b[7:0]), 32'hFF);
    check("fail_done", 32'(cal_done), 0);
    check("fail_nowords", en_cnt - base, 0);
    rng_en = 1'b0;
    idle(2);
    check("fail_sticky_off", 32'(cal_fail), 1);
    check("croen_off", 32'(cro_en), 0);
    check("sel_keep", 32'(sel_b), 32'h80FF);
    rng_en = 1'b1;
    idle(2);
    check("fail_sticky_on", 32'(cal_fail), 1);
    rst_x = 1'b0;
    idle(1);
    check("fail_clr", 32'(cal_fail), 0);
    check("sel_reinit", 32'(sel_b), 32'h8080);
    rst_x = 1'b1;
    mrep = 0;
    mherr = 1'b0;
    mcnt = 0;
    mword = '0;
    repeat (6) begin strobe(8'd20, 8'd20, 2'b11); idle(1); end
    idle(2);
    check("relock_lo", 32'(cal_done), 1);
    base = en_cnt;
    wbase = exp_words;
    for (int i = 0; i < 48; i++) pair(8'd40, 8'd40);
    idle(1);
    check("zero_words", en_cnt - base, 32'(exp_words - wbase));
    check("herr", 32'(health_err), 32'(mherr));
    idle(3);
    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
